// File: rtl/proc_turnaround_pkg.sv
// Shared types and sizing helpers for the pin turnaround block and its input filter.
package proc_turnaround_pkg;

    typedef enum logic [1:0] {
        ST_IN   = 2'd0,
        ST_DEAD = 2'd1,
        ST_OUT  = 2'd2
    } proc_state_t;

    // Bits needed for a counter that must hold the values 0..max_val (never less than 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/proc_turnaround_in_filter.sv
// One pin bit: 2-FF synchroniser followed by a stability filter that only runs while enabled.
module proc_in_filter
    import proc_turnaround_pkg::*;
#(
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic pin_async,
    output logic pin_filt
);

    localparam int CW = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = pin_async;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        // Counter stays cleared while disabled, so re-entry never inherits stale samples.
        if (en) begin
            if (cnt_q == CNT_MAX) begin
                filt_d = ~filt_q;
            end else if (sync2_q != filt_q) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pin_filt = filt_q;

endmodule

// File: rtl/proc_turnaround.sv
// Bidirectional pin turnaround: IN/DEAD/OUT sequencing with a guaranteed enable gap,
// registered drive path and per-bit synchronised, filtered receive path.
module proc_turnaround
    import proc_turnaround_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int DEAD_CYCLES   = 4,
    parameter int FILTER_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] virtual_out,
    output logic [WIDTH-1:0] internal_out,
    input  logic [WIDTH-1:0] internal_in,
    output logic [WIDTH-1:0] virtual_in,
    input  logic             dir_req,
    output logic             output_enable,
    output logic             input_enable,
    output logic             dir_ack,
    output logic             busy
);

    localparam int DW = cnt_width(DEAD_CYCLES);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

    proc_state_t      state_q, state_d;
    logic [DW-1:0]    dead_cnt_q, dead_cnt_d;
    logic [WIDTH-1:0] iout_q, iout_d;
    logic             oe_q, oe_d;
    logic             ie_q, ie_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             filt_en;

    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        case (state_q)
            ST_IN: begin
                if (dir_req) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = DEAD_LOAD;
                end
            end
            ST_OUT: begin
                if (!dir_req) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = DEAD_LOAD;
                end
            end
            ST_DEAD: begin
                // Dead time always runs to completion; only dir_req on the last cycle matters.
                if (dead_cnt_q == '0) begin
                    state_d = dir_req ? ST_OUT : ST_IN;
                end else begin
                    dead_cnt_d = dead_cnt_q - DW'(1);
                end
            end
            default: begin
                state_d    = ST_IN;
                dead_cnt_d = '0;
            end
        endcase

        oe_d   = (state_d == ST_OUT);
        ie_d   = (state_d == ST_IN);
        busy_d = (state_d == ST_DEAD);
        iout_d = oe_d ? virtual_out : '0;
        ack_d  = ((state_q == ST_OUT) && dir_req) || ((state_q == ST_IN) && !dir_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IN;
            dead_cnt_q <= '0;
            iout_q     <= '0;
            oe_q       <= 1'b0;
            ie_q       <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dead_cnt_q <= dead_cnt_d;
            iout_q     <= iout_d;
            oe_q       <= oe_d;
            ie_q       <= ie_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    assign filt_en = (state_q == ST_IN);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_in_bit
            proc_in_filter #(
                .FILTER_CYCLES(FILTER_CYCLES)
            ) u_in_filter (
                .clk      (clk),
                .rst      (rst),
                .en       (filt_en),
                .pin_async(internal_in[gi]),
                .pin_filt (virtual_in[gi])
            );
        end
    endgenerate

    assign internal_out  = iout_q;
    assign output_enable = oe_q;
    assign input_enable  = ie_q;
    assign busy          = busy_q;
    assign dir_ack       = ack_q;

endmodule

// File: tb/tb_proc_turnaround.sv
// Directed bench for proc_turnaround: reset, turnaround timing, drive path, input filter, random gap check.
module tb_proc_turnaround;

    localparam int WIDTH = 16;
    localparam int DEAD  = 4;
    localparam int FILT  = 3;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] virtual_out;
    logic [WIDTH-1:0] internal_out;
    logic [WIDTH-1:0] internal_in;
    logic [WIDTH-1:0] virtual_in;
    logic             dir_req;
    logic             output_enable;
    logic             input_enable;
    logic             dir_ack;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    proc_turnaround #(
        .WIDTH        (WIDTH),
        .DEAD_CYCLES  (DEAD),
        .FILTER_CYCLES(FILT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .virtual_out  (virtual_out),
        .internal_out (internal_out),
        .internal_in  (internal_in),
        .virtual_in   (virtual_in),
        .dir_req      (dir_req),
        .output_enable(output_enable),
        .input_enable (input_enable),
        .dir_ack      (dir_ack),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int gap;
        rst         = 1'b1;
        dir_req     = 1'b0;
        virtual_out = '0;
        internal_in = '0;
        repeat (3) tick();

        // reset state
        chk("rst_oe",   32'(output_enable), 32'd0);
        chk("rst_ie",   32'(input_enable),  32'd1);
        chk("rst_busy", 32'(busy),          32'd0);
        chk("rst_ack",  32'(dir_ack),       32'd0);
        chk("rst_vin",  32'(virtual_in),    32'd0);
        chk("rst_iout", 32'(internal_out),  32'd0);

        // IN -> DEAD -> OUT, dir_req=1 at cycle 0
        rst     = 1'b0;
        dir_req = 1'b1;
        tick();
        chk("c1_ie",   32'(input_enable),  32'd0);
        chk("c1_oe",   32'(output_enable), 32'd0);
        chk("c1_busy", 32'(busy),          32'd1);
        tick();
        chk("c2_busy", 32'(busy), 32'd1);
        tick();
        chk("c3_busy", 32'(busy), 32'd1);
        tick();
        chk("c4_busy", 32'(busy),          32'd1);
        chk("c4_oe",   32'(output_enable), 32'd0);
        tick();
        chk("c5_oe",   32'(output_enable), 32'd1);
        chk("c5_busy", 32'(busy),          32'd0);
        chk("c5_ack",  32'(dir_ack),       32'd0);
        tick();
        chk("c6_ack",  32'(dir_ack), 32'd1);

        // drive path in OUT
        virtual_out = 16'hA55A;
        tick();
        chk("iout_a55a", 32'(internal_out), 32'h0000A55A);
        virtual_out = 16'h1234;
        tick();
        chk("iout_1234", 32'(internal_out), 32'h00001234);

        // OUT -> DEAD with dir_req toggling 1,0,1: full dead time, back to OUT
        dir_req = 1'b0;
        tick();
        chk("d1_iout", 32'(internal_out),  32'd0);
        chk("d1_oe",   32'(output_enable), 32'd0);
        chk("d1_busy", 32'(busy),          32'd1);
        dir_req = 1'b1;
        tick();
        chk("d2_busy", 32'(busy), 32'd1);
        dir_req = 1'b0;
        tick();
        chk("d3_busy", 32'(busy), 32'd1);
        dir_req = 1'b1;
        tick();
        chk("d4_busy", 32'(busy),          32'd1);
        chk("d4_oe",   32'(output_enable), 32'd0);
        tick();
        chk("ret_out_oe",   32'(output_enable), 32'd1);
        chk("ret_out_busy", 32'(busy),          32'd0);

        // OUT -> DEAD with final dir_req=0: back to IN after 4 cycles
        dir_req = 1'b0;
        tick();
        chk("e1_busy", 32'(busy), 32'd1);
        dir_req = 1'b1;
        tick();
        tick();
        dir_req = 1'b0;
        tick();
        chk("e4_ie",   32'(input_enable), 32'd0);
        chk("e4_busy", 32'(busy),         32'd1);
        tick();
        chk("in_ie",   32'(input_enable), 32'd1);
        chk("in_busy", 32'(busy),         32'd0);
        tick();
        chk("in_ack",  32'(dir_ack), 32'd1);

        // input filter: bit0 steady high appears exactly 6 cycles later
        internal_in = 16'h0001;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("vin0_c%0d", i), 32'(virtual_in), 32'd0);
        end
        tick();
        chk("vin0_c6", 32'(virtual_in), 32'd1);

        // 2-cycle glitch on bit1 is rejected
        internal_in = 16'h0003;
        tick();
        tick();
        internal_in = 16'h0001;
        repeat (8) tick();
        chk("vin1_glitch", 32'(virtual_in), 32'd1);

        // go to OUT, then reset: immediate drop, no dead time
        dir_req = 1'b1;
        repeat (5) tick();
        chk("pre_rst_oe",   32'(output_enable), 32'd1);
        chk("pre_rst_iout", 32'(internal_out),  32'h00001234);
        rst = 1'b1;
        tick();
        chk("rst_out_oe",   32'(output_enable), 32'd0);
        chk("rst_out_ie",   32'(input_enable),  32'd1);
        chk("rst_out_vin",  32'(virtual_in),    32'd0);
        chk("rst_out_busy", 32'(busy),          32'd0);
        chk("rst_out_iout", 32'(internal_out),  32'd0);

        // reset mid-DEAD
        rst = 1'b0;
        tick();
        chk("mid_dead_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_dead_busy", 32'(busy),         32'd0);
        chk("rst_dead_ie",   32'(input_enable), 32'd1);

        // first post-reset cycle with dir_req=1 starts a full dead period
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("pr_busy_c%0d", i), 32'(busy), 32'd1);
        end
        tick();
        chk("pr_oe_c5", 32'(output_enable), 32'd1);

        // random dir_req / internal_in: never both enables, exact gap
        rst = 1'b1;
        dir_req = 1'b0;
        tick();
        rst = 1'b0;
        gap = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) dir_req = ~dir_req;
            internal_in = WIDTH'($urandom);
            tick();
            chk("no_overlap", 32'(output_enable && input_enable), 32'd0);
            if (!output_enable && !input_enable) begin
                gap++;
            end else begin
                if (gap != 0) chk("gap_len", 32'(gap), 32'(DEAD));
                gap = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
